// File: rtl/pipelined_carry_select_adder_pkg.sv
// Shared types and helpers for the pipelined carry-select add/sub datapath.
//   MAX_WIDTH : widest operand the stage-register struct can carry
//   op_e      : operation select (OP_ADD / OP_SUB)
//   stage_t   : one pipeline stage register (sum so far, carry, MSB carry,
//               operands still to be resolved, valid)
//   seg_width : number of result bits resolved per pipeline stage
package adder_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Stage fields are sized for MAX_WIDTH; only the low WIDTH bits carry data.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic                 carry;
        logic                 msb_carry;
        logic                 valid;
    } stage_t;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_if.sv
// Handshake and data bundle for the pipelined carry-select adder.
//   in_valid/in_ready   : operand-side handshake
//   a, b, cin, sub      : operands, carry in, subtract select
//   out_valid/out_ready : result-side handshake
//   sum, cout, ovf      : result, carry out (no-borrow in sub mode), overflow
// slave is the adder's view, master is the producer/consumer view.
interface pipelined_carry_select_adder_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipelined_carry_select_adder_csa_block.sv
// Combinational BLOCK-bit carry-select cell.
//   a, b : operand slices
//   c    : incoming carry
//   s    : sum slice
//   co   : carry out of the slice
// Both carry-in outcomes are computed up front; the late-arriving carry only
// drives the final mux.
module csa_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c,
    output logic [BLOCK-1:0] s,
    output logic             co
);

    logic [BLOCK:0] r0_s;
    logic [BLOCK:0] r1_s;

    assign r0_s = {1'b0, a} + {1'b0, b};
    assign r1_s = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

    assign s  = c ? r1_s[BLOCK-1:0] : r0_s[BLOCK-1:0];
    assign co = c ? r1_s[BLOCK]     : r0_s[BLOCK];

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined, parametrised carry-select adder/subtractor.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of pipelined_carry_select_adder_if
// Stage k resolves bits [k*SEG +: SEG] from the carry registered by stage k-1.
// All stages advance together whenever the output register is empty or is
// being consumed; in_ready is that advance condition.
module pipelined_carry_select_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipelined_carry_select_adder_if.slave bus
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int NBLK = SEG / BLOCK;

    if (WIDTH % STAGES != 0) begin : g_err_stages
        $error("pipelined_carry_select_adder: WIDTH must be a multiple of STAGES");
    end
    if (SEG % BLOCK != 0) begin : g_err_block
        $error("pipelined_carry_select_adder: SEG must be a multiple of BLOCK");
    end
    if (WIDTH > MAX_WIDTH) begin : g_err_width
        $error("pipelined_carry_select_adder: WIDTH exceeds MAX_WIDTH");
    end

    stage_t head_s;
    stage_t last_s;
    op_e    op_s;
    logic   adv_s;
    logic   unused_last_s;

    assign op_s  = op_e'(bus.sub);
    assign adv_s = !last_s.valid || bus.out_ready;

    // Resolve operation into effective operand B and carry before stage 1.
    always_comb begin
        head_s               = '0;
        head_s.a[WIDTH-1:0]  = bus.a;
        head_s.valid         = bus.in_valid;
        if (op_s == OP_SUB) begin
            head_s.b[WIDTH-1:0] = ~bus.b;
            head_s.carry        = 1'b1;
        end else begin
            head_s.b[WIDTH-1:0] = bus.b;
            head_s.carry        = bus.cin;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t          src_s;
        stage_t          stage_next_s;
        stage_t          stage_r;
        logic [SEG-1:0]  seg_a_s;
        logic [SEG-1:0]  seg_b_s;
        logic [SEG-1:0]  seg_sum_s;
        logic [NBLK:0]   c_s;

        if (k == 0) begin : g_src_head
            assign src_s = head_s;
        end else begin : g_src_prev
            assign src_s = g_stage[k-1].stage_r;
        end

        assign seg_a_s = src_s.a[k*SEG +: SEG];
        assign seg_b_s = src_s.b[k*SEG +: SEG];
        assign c_s[0]  = src_s.carry;

        for (genvar j = 0; j < NBLK; j++) begin : g_blk
            csa_block #(.BLOCK(BLOCK)) u_csa (
                .a  (seg_a_s[j*BLOCK +: BLOCK]),
                .b  (seg_b_s[j*BLOCK +: BLOCK]),
                .c  (c_s[j]),
                .s  (seg_sum_s[j*BLOCK +: BLOCK]),
                .co (c_s[j+1])
            );
        end

        // Merge this segment's result into the travelling stage record.
        always_comb begin
            stage_next_s                   = src_s;
            stage_next_s.sum[k*SEG +: SEG] = seg_sum_s;
            stage_next_s.carry             = c_s[NBLK];
            // Carry into the segment MSB recovered from its sum bit; only
            // the last stage's value (true MSB of the word) is consumed.
            stage_next_s.msb_carry         = seg_sum_s[SEG-1] ^ seg_a_s[SEG-1] ^ seg_b_s[SEG-1];
        end

        // Stage register: shifts with the whole pipe, holds (bubbles too) on stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_r <= '0;
            end else if (adv_s) begin
                stage_r <= stage_next_s;
            end
        end
    end

    assign last_s        = g_stage[STAGES-1].stage_r;
    assign unused_last_s = ^last_s;

    assign bus.in_ready  = adv_s;
    assign bus.out_valid = last_s.valid;
    assign bus.sum       = last_s.sum[WIDTH-1:0];
    assign bus.cout      = last_s.carry;
    assign bus.ovf       = last_s.msb_carry ^ last_s.carry;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder (WIDTH=16, STAGES=2, BLOCK=4).
// A scoreboard queue receives a reference result on every input handshake and
// is compared on every output handshake; directed steps add latency, stall,
// bubble and reset checks against constants.
module tb_pipelined_carry_select_adder;

    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [W+1:0] sb[$];
    logic [W+1:0] exp_r;

    pipelined_carry_select_adder_if #(.WIDTH(W)) bus ();

    pipelined_carry_select_adder #(.WIDTH(W), .STAGES(2), .BLOCK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   full;
        logic         ov;
        bb   = ms ? ~mb : mb;
        ci   = ms ? 1'b1 : mc;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
        ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts);
        bus.in_valid = v;
        bus.a        = ta;
        bus.b        = tb;
        bus.cin      = tc;
        bus.sub      = ts;
    endtask

    task automatic single(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
        cyc();
        drive(1'b1, ta, tb, tc, ts);
        cyc();
        bus.in_valid = 1'b0;
        chk("lat_not_early", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("dir_sum", 32'(bus.sum), 32'(es));
        chk("dir_cout", 32'(bus.cout), 32'(ec));
        chk("dir_ovf", 32'(bus.ovf), 32'(eo));
    endtask

    // Scoreboard: compare on output handshake, enqueue on input handshake.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_r = sb.pop_front();
                chk("sb_sum", 32'(bus.sum), 32'(exp_r[W-1:0]));
                chk("sb_cout", 32'(bus.cout), 32'(exp_r[W]));
                chk("sb_ovf", 32'(bus.ovf), 32'(exp_r[W+1]));
            end
        end
        if (rst_n && bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_v;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Directed add / sub / overflow cases
        single(16'd14, 16'd1, 1'b1, 1'b0, 16'd16, 1'b0, 1'b0);
        single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        single(16'd5, 16'd7, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: back-to-back stream with a 3-cycle stall
        cyc();
        drive(1'b1, 16'd999, 16'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 16'd5, 16'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 16'd0, 16'd0, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_sum", 32'(bus.sum), 32'd999);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_stall_sum", 32'(bus.sum), 32'd999);
        end
        bus.out_ready = 1'b1;
        cyc();
        chk("bp_r1_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_r1_sum", 32'(bus.sum), 32'd5);
        drive(1'b1, 16'd14, 16'd1, 1'b1, 1'b0);
        cyc();
        chk("bp_r2_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_r2_sum", 32'(bus.sum), 32'd1);
        bus.in_valid = 1'b0;
        cyc();
        chk("bp_r3_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_r3_sum", 32'(bus.sum), 32'd16);
        cyc();
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // Bubbles: alternating in_valid, results lag by two cycles
        for (int i = 0; i < 12; i++) begin
            cyc();
            exp_v = (i >= 2) && ((i - 2) % 2 == 0) && ((i - 2) < 8);
            chk("bubble_valid", 32'(bus.out_valid), 32'(exp_v));
            drive(((i % 2) == 0) && (i < 8), 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom));
        end
        bus.in_valid = 1'b0;

        // Reset mid-flight with two transactions in the pipe
        cyc();
        drive(1'b1, 16'd100, 16'd23, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 16'd7, 16'd9, 1'b0, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum", 32'(bus.sum), 32'd0);
        chk("mid_rst_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        single(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h0123, 1'b1, 1'b0);

        repeat (4) cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_select_adder.md
Name: pipelined_carry_select_adder

Overview:
- Parametrised, pipelined successor to the 16-bit carry-select adder.
- Operand width, segment/pipeline depth and carry-select block size are all configurable.
- Supports add and subtract modes, reports signed overflow, and uses valid/ready handshakes on both sides.
- Sits between operand producers and an ALU result stage; it is the team's reusable add/sub datapath.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- STAGES, 2, number of pipeline stages; each stage resolves SEG = WIDTH/STAGES bits.
- BLOCK, 4, carry-select block width inside a segment; SEG must be divisible by BLOCK.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands present.
- in_ready, output, 1, adder can accept this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry in; ignored when sub=1.
- sub, input, 1, 1 = compute a - b.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts result.
- sum, output, WIDTH, result.
- cout, output, 1, carry out; in sub mode 1 = no borrow (a >= b unsigned).
- ovf, output, 1, two's-complement overflow.

Behaviour:
- Elaboration: error if WIDTH % STAGES != 0 or SEG % BLOCK != 0.
- Reset (async, rst_n=0): all stage valid bits clear; out_valid=0, sum=0, cout=0, ovf=0. In-flight data is discarded. The first output after rst_n rises comes only from a new acceptance.
- Sub mode: b_eff = ~b, carry in forced to 1. Add mode: b_eff = b, carry in = cin. Both are resolved before stage 1.
- Stage k (1..STAGES) computes bits [(k-1)*SEG +: SEG] from the registered carry of stage k-1.
- Each stage is built from SEG/BLOCK carry-select blocks. Every block precomputes sum/carry for carry-in 0 and 1 and muxes on the incoming carry.
- Each stage registers its sum slice, the carry out, the carry into the MSB (last stage only), the untouched upper operand bits, and a valid bit.
- Latency: a transaction accepted on edge n is presented on out_valid/sum after edge n+STAGES-1 (STAGES register stages). Throughput is 1 per cycle when out_ready=1.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages shift together when adv=1 and hold when adv=0.
- Bubbles are not collapsed: a stalled empty stage stays empty.
- Acceptance happens when in_valid && in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 1.
- Output stability: while out_valid=1 && out_ready=0, sum/cout/ovf hold bit-exact.
- ovf = carry into MSB XOR carry out of MSB, in both modes.
- Width rule: sum is exactly WIDTH bits; wrap-around is modulo 2^WIDTH; cout carries the extra bit.
- Ordering: results leave strictly in acceptance order. No transaction is dropped or duplicated under any out_ready pattern.
- Simultaneous accept and output on the same edge is legal and required for full throughput.

Decomposition:
- Package adder_pkg holds: the SEG derivation function, an op-mode constant (OP_ADD=0, OP_SUB=1), and the stage-register struct typedef (sum slice, carry, msb carry, operands, valid).
- One natural sub-module, csa_block: combinational BLOCK-bit carry-select cell with ports a, b, c, s, co. It is instantiated SEG/BLOCK times per stage.
- The stage chain is generated inside the top module.

Test Plan (defaults WIDTH=16, STAGES=2, BLOCK=4):
- Basic add: a=14, b=1, cin=1, sub=0, out_ready=1 -> after 2 edges sum=16, cout=0, ovf=0.
- Unsigned and signed overflow: 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: 5-7, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 999+0, 5+0, 0+0 cin=1, 14+1 cin=1 back-to-back; hold out_ready=0 for 3 cycles once out_valid rises.
  - Expected: in_ready=0 while stalled, output 999 held stable, then results 999, 5, 1, 16 in order with no gaps after release.
- Bubbles: alternate in_valid 1/0 with out_ready=1 -> out_valid alternates with a 2-cycle lag; sums match a reference model.
- Reset mid-flight: two transactions in the pipe, pulse rst_n low mid-cycle (not on an edge).
  - Expected: out_valid=0 and sum=0 immediately, and no stale result appears after reset release.
